// File: rtl/vending_machine_multi.sv
// Multi-drink vending machine: coin collection, purchase, coin change.
// Ports: clk, rst (sync, active-high); coin_type, drink_sel, buy,
//   cancel in; vend, vend_id, change, coin_reject, buy_fail, credit,
//   busy out (all registered, credit/change in 50-won units).
module vending_machine_multi #(
    parameter int N_DRINK = 4,
    parameter int CREDIT_W = 4,
    parameter int MAX_CREDIT = 10,
    parameter logic [N_DRINK*CREDIT_W-1:0] PRICE_LIST =
        {4'd2, 4'd4, 4'd5, 4'd6},
    localparam int SEL_W = $clog2(N_DRINK)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin_type,
    input  logic [SEL_W-1:0]    drink_sel,
    input  logic                buy,
    input  logic                cancel,
    output logic                vend,
    output logic [SEL_W-1:0]    vend_id,
    output logic [1:0]          change,
    output logic                coin_reject,
    output logic                buy_fail,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    state_t state, state_n;

    logic [CREDIT_W-1:0] residual, residual_n;
    logic [CREDIT_W-1:0] credit_n;
    logic                vend_n;
    logic [SEL_W-1:0]    vend_id_n;
    logic [1:0]          change_n;
    logic                reject_n;
    logic                fail_n;

    logic [CREDIT_W-1:0] price_tab [N_DRINK];
    logic [CREDIT_W-1:0] price;
    logic                sel_ok;
    logic [CREDIT_W:0]   coin_sum;

    // First coin of a refund drawn from credit (cancel path) and the
    // next coin drawn from residual (VEND/CHANGE path): 100 won first.
    logic [1:0]          cc_coin, rc_coin;
    logic [CREDIT_W-1:0] cc_rest, rc_rest;

    always_comb begin
        for (int i = 0; i < N_DRINK; i++) begin
            price_tab[i] = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        end
    end

    assign sel_ok = int'(drink_sel) < N_DRINK;
    assign price  = sel_ok ? price_tab[drink_sel] : '0;

    // coin_type 01/10 numerically equals its value in 50-won units.
    assign coin_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_type);

    always_comb begin
        if (credit >= CREDIT_W'(2)) begin
            cc_coin = 2'b10;
            cc_rest = credit - CREDIT_W'(2);
        end else begin
            cc_coin = 2'b01;
            cc_rest = credit - CREDIT_W'(1);
        end
        if (residual >= CREDIT_W'(2)) begin
            rc_coin = 2'b10;
            rc_rest = residual - CREDIT_W'(2);
        end else begin
            rc_coin = 2'b01;
            rc_rest = residual - CREDIT_W'(1);
        end
    end

    always_comb begin
        state_n    = state;
        credit_n   = credit;
        residual_n = residual;
        vend_n     = 1'b0;
        vend_id_n  = '0;
        change_n   = 2'b00;
        reject_n   = 1'b0;
        fail_n     = 1'b0;
        unique case (state)
            COLLECT: begin
                if (cancel && credit != '0) begin
                    // First refund coin leaves on the cancel edge.
                    state_n    = CHANGE;
                    change_n   = cc_coin;
                    residual_n = cc_rest;
                    credit_n   = cc_rest;
                    reject_n   = coin_type != 2'b00;
                end else if (buy && sel_ok && credit >= price) begin
                    state_n    = VEND;
                    vend_n     = 1'b1;
                    vend_id_n  = drink_sel;
                    residual_n = credit - price;
                    credit_n   = credit - price;
                    reject_n   = coin_type != 2'b00;
                end else begin
                    // A refused buy still lets the coin through.
                    fail_n = buy;
                    if (coin_type == 2'b11) begin
                        reject_n = 1'b1;
                    end else if (coin_type != 2'b00) begin
                        if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                            credit_n = coin_sum[CREDIT_W-1:0];
                        end else begin
                            reject_n = 1'b1;
                        end
                    end
                end
            end
            VEND, CHANGE: begin
                reject_n = coin_type != 2'b00;
                if (residual == '0) begin
                    state_n  = COLLECT;
                    credit_n = '0;
                end else begin
                    state_n    = CHANGE;
                    change_n   = rc_coin;
                    residual_n = rc_rest;
                    credit_n   = rc_rest;
                end
            end
            default: begin
                state_n    = COLLECT;
                credit_n   = '0;
                residual_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            credit      <= '0;
            residual    <= '0;
            vend        <= 1'b0;
            vend_id     <= '0;
            change      <= 2'b00;
            coin_reject <= 1'b0;
            buy_fail    <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            residual    <= residual_n;
            vend        <= vend_n;
            vend_id     <= vend_id_n;
            change      <= change_n;
            coin_reject <= reject_n;
            buy_fail    <= fail_n;
        end
    end

    assign busy = state != COLLECT;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin_type = '0;
    logic [1:0] drink_sel = '0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic       vend;
    logic [1:0] vend_id;
    logic [1:0] change;
    logic       coin_reject;
    logic       buy_fail;
    logic [3:0] credit;
    logic       busy;

    vending_machine_multi dut (
        .clk(clk),
        .rst(rst),
        .coin_type(coin_type),
        .drink_sel(drink_sel),
        .buy(buy),
        .cancel(cancel),
        .vend(vend),
        .vend_id(vend_id),
        .change(change),
        .coin_reject(coin_reject),
        .buy_fail(buy_fail),
        .credit(credit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vend;
        int id;
        int chg;
        bit rej;
        bit fail;
        int cred;
        bit busy;
    } rec_t;

    int   price [4] = '{6, 5, 4, 2};
    rec_t mdl;
    rec_t plan_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Queue the output cycles of a purchase or refund: optional vend
    // cycle, one cycle per coin (largest first), then idle with 0 credit.
    task automatic plan(input bit v, input int id, input int amt);
        rec_t r;
        int   left;
        left = amt;
        if (v) begin
            r = '{default: 0};
            r.vend = 1;
            r.id = id;
            r.cred = left;
            r.busy = 1;
            plan_q.push_back(r);
        end
        while (left > 0) begin
            r = '{default: 0};
            r.chg = (left >= 2) ? 2 : 1;
            left -= r.chg;
            r.cred = left;
            r.busy = 1;
            plan_q.push_back(r);
        end
        r = '{default: 0};
        plan_q.push_back(r);
    endtask

    task automatic model(input bit r, input int c, input int s,
                         input bit b, input bit k);
        rec_t nx;
        bit   took;
        nx = '{default: 0};
        took = 0;
        if (r) begin
            plan_q.delete();
        end else if (mdl.busy) begin
            if (plan_q.size() > 0) nx = plan_q.pop_front();
            nx.rej = c != 0;
        end else begin
            nx.cred = mdl.cred;
            if (k && mdl.cred > 0) begin
                plan(0, 0, mdl.cred);
                took = 1;
            end else if (b) begin
                if (mdl.cred >= price[s]) begin
                    plan(1, s, mdl.cred - price[s]);
                    took = 1;
                end else begin
                    nx.fail = 1;
                end
            end
            if (took) begin
                nx = plan_q.pop_front();
                nx.rej = c != 0;
            end else if (c == 3) begin
                nx.rej = 1;
            end else if (c != 0) begin
                if (mdl.cred + c <= 10) nx.cred = mdl.cred + c;
                else nx.rej = 1;
            end
        end
        mdl = nx;
    endtask

    task automatic step(input bit r, input int c, input int s,
                        input bit b, input bit k);
        rst = r;
        coin_type = 2'(c);
        drink_sel = 2'(s);
        buy = b;
        cancel = k;
        @(posedge clk);
        #1;
        model(r, c, s, b, k);
        chk("vend", int'(vend), int'(mdl.vend));
        chk("vend_id", int'(vend_id), mdl.id);
        chk("change", int'(change), mdl.chg);
        chk("coin_reject", int'(coin_reject), int'(mdl.rej));
        chk("buy_fail", int'(buy_fail), int'(mdl.fail));
        chk("credit", int'(credit), mdl.cred);
        chk("busy", int'(busy), int'(mdl.busy));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        mdl = '{default: 0};

        step(1, 3, 2, 1, 1);
        chk("rst_credit", int'(credit), 0);

        // Exact pay for drink0.
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        chk("exact_cred", int'(credit), 6);
        step(0, 0, 0, 1, 0);
        chk("exact_vend", int'(vend), 1);
        idle();
        chk("exact_done", int'(credit), 0);
        chk("exact_chg", int'(change), 0);

        // Overpay 350 for drink1, coin offered during VEND.
        step(1, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("over_id", int'(vend_id), 1);
        step(0, 1, 0, 0, 0);
        chk("over_chg", int'(change), 2);
        chk("over_rej", int'(coin_reject), 1);
        idle();
        chk("over_busy", int'(busy), 0);

        // Cancel 250.
        step(0, 1, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("cancel_c1", int'(change), 2);
        idle();
        idle();
        chk("cancel_c3", int'(change), 1);
        idle();
        idle();

        // Overflow and invalid coin.
        for (int i = 0; i < 4; i++) step(0, 2, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        chk("ovf_rej", int'(coin_reject), 1);
        chk("ovf_cred", int'(credit), 9);
        step(0, 3, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("ovf_max", int'(credit), 10);

        // Reset mid-change.
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("rst_mid_chg", int'(change), 0);
        idle();
        idle();

        // Insufficient, then exact buy with a coin in the same cycle.
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("insuf_fail", int'(buy_fail), 1);
        chk("insuf_cred", int'(credit), 4);
        step(0, 1, 2, 1, 0);
        chk("buy2_vend", int'(vend), 1);
        step(0, 2, 0, 0, 0);
        chk("busy_rej", int'(coin_reject), 1);
        idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 Parameter N_DRINK, default 4: number of selectable drinks (2..16).
REQ-002 Parameter CREDIT_W, default 4: credit register width, in 50-won units.
REQ-003 Parameter MAX_CREDIT, default 10: maximum accepted credit in 50-won units (500 won); SHALL be at most 2^CREDIT_W-1.
REQ-004 Parameter PRICE_LIST, default {4'd2,4'd4,4'd5,4'd6}: packed N_DRINK x CREDIT_W prices in 50-won units; drink i occupies bits [i*CREDIT_W +: CREDIT_W], so drink0=300, drink1=250, drink2=200, drink3=100 won.
REQ-005 Single clock; reset is synchronous and active-high. Ports use the codebase names clk and rst.
REQ-006 clk  input  1  system clock, all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 coin_type  input  2  coin offered this cycle: 00 none, 01 = 50 won, 10 = 100 won, 11 invalid.
REQ-009 drink_sel  input  SEL_W=$clog2(N_DRINK)  drink index, sampled only when buy=1.
REQ-010 buy  input  1  single-cycle purchase request.
REQ-011 cancel  input  1  single-cycle refund request.
REQ-012 vend  output  1  one-cycle pulse, drink released.
REQ-013 vend_id  output  SEL_W  index of the vended drink; valid while vend=1, 0 otherwise.
REQ-014 change  output  2  coin returned this cycle: 00 none, 01 = 50 won, 10 = 100 won.
REQ-015 coin_reject  output  1  one-cycle pulse, the offered coin was returned unaccepted.
REQ-016 buy_fail  output  1  one-cycle pulse, buy refused.
REQ-017 credit  output  CREDIT_W  current accepted credit.
REQ-018 busy  output  1  high in VEND and CHANGE states.

Function
REQ-019 All outputs SHALL be registered; every response SHALL appear exactly one cycle after the input edge that caused it.
REQ-020 The FSM SHALL have three states: COLLECT, VEND and CHANGE.
REQ-021 COLLECT, valid coin: credit += value (1 or 2 units) when the sum is at most MAX_CREDIT. Otherwise the credit SHALL stay unchanged and coin_reject=1.
REQ-022 COLLECT, coin_type=11: coin_reject=1 and credit unchanged.
REQ-023 COLLECT, buy=1 with drink_sel >= N_DRINK or credit < price: buy_fail=1, credit unchanged, state stays COLLECT.
REQ-024 COLLECT, buy=1 with credit >= price: state goes to VEND and residual is set to credit - price.
- On entering VEND: vend=1 and vend_id=drink_sel for one cycle, and credit is set to residual.
- Exact credit (residual=0): next state is COLLECT.
- Otherwise: next state is CHANGE.
REQ-025 COLLECT, cancel=1 with credit>0: state goes to CHANGE and residual is set to credit. With credit=0, cancel SHALL be ignored.
REQ-026 Priority within one COLLECT cycle SHALL be cancel > buy > coin.
- A coin presented in the same cycle as an accepted cancel or buy SHALL be rejected (coin_reject=1).
- buy is evaluated against the credit held before that cycle's coin.
REQ-027 CHANGE emits one coin per cycle:
- change=10 and residual -= 2 while residual >= 2.
- Otherwise change=01 and residual -= 1.
- credit SHALL track the residual.
- Return to COLLECT in the cycle after the last coin, with credit=0.
REQ-028 VEND/CHANGE (busy=1):
- buy and cancel SHALL be ignored, with no buy_fail.
- Any nonzero coin_type SHALL produce coin_reject=1.
REQ-029 change SHALL be 00 in all states except CHANGE. vend SHALL never be high in the same cycle as a nonzero change.
REQ-030 The sum of returned change SHALL equal credit minus the price of any vended drink. Credit SHALL never exceed MAX_CREDIT and never underflow.

Reset
REQ-031 rst=1 at a clock edge SHALL force the following, regardless of state or other inputs, including mid-CHANGE:
- state=COLLECT, credit=0, residual=0.
- vend=0, vend_id=0, change=00, coin_reject=0, buy_fail=0, busy=0.
REQ-032 Undispensed residual is lost on reset; no coins SHALL be emitted after reset until a new transaction.

Verification
REQ-033 Exact pay: 100, 100, 100 won then buy drink0 -> credit=6, vend=1 with vend_id=0, change 00, credit=0, back to COLLECT.
REQ-034 Overpay with change: coins totalling 350 won then buy drink1 (250) -> vend=1 with vend_id=1, then change 10 for 1 cycle, credit=0, busy low.
REQ-035 Cancel: 50+100+100 won then cancel -> change 10, 10, 01 on consecutive cycles, no vend, credit=0.
REQ-036 Overflow/invalid: credit=9, then coin 100 -> coin_reject=1 and credit stays 9; coin 11 -> coin_reject=1; coin 50 -> credit=10.
REQ-037 Insufficient and busy: credit=4, then buy drink0 -> buy_fail=1 and credit=4. Then buy drink2 -> vend. A coin offered during CHANGE/VEND -> coin_reject=1.
REQ-038 Reset mid-CHANGE: credit=10, cancel, rst asserted after the first change coin -> next cycle all outputs 0, credit=0, no further change coins.
